// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
// Retires ALU results in order from a 2-entry FIFO. ALU ops become register-file
// writes (held until the register file takes them), taken branches become a
// one-cycle redirect pulse that also squashes every younger buffered entry.
// All outputs are registered; a head entry is decoded into the output
// registers on the edge it becomes the issuing entry.
module alu_writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 7,
  parameter int OP_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_result,
  input  logic [REG_W-1:0]  in_branch,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  output logic              br_taken,
  output logic [REG_W-1:0]  br_target,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

  // FIFO storage and bookkeeping
  logic [OP_W-1:0]   r_mem_op  [2];
  logic [REG_W-1:0]  r_mem_rd  [2];
  logic [DATA_W-1:0] r_mem_res [2];
  logic [REG_W-1:0]  r_mem_br  [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  state_t            r_state;
  state_t            w_state_next;

  // Registered outputs
  logic              r_rf_we;
  logic [REG_W-1:0]  r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_br_taken;
  logic [REG_W-1:0]  r_br_target;
  logic [CNT_W-1:0]  r_retired;

  logic              w_rf_we_next;
  logic [REG_W-1:0]  w_rf_waddr_next;
  logic [DATA_W-1:0] w_rf_wdata_next;
  logic              w_br_taken_next;
  logic [REG_W-1:0]  w_br_target_next;

  logic              w_push;
  logic              w_done;
  logic              w_more;
  logic              w_load;
  logic [OP_W-1:0]   w_head_op;
  logic [OP_W-1:0]   w_sel_op;
  logic [REG_W-1:0]  w_sel_rd;
  logic [DATA_W-1:0] w_sel_res;
  logic [REG_W-1:0]  w_sel_br;
  logic              w_is_alu;
  logic              w_is_br;
  logic              w_we_dec;
  logic              w_br_dec;

  // The redirect cycle blocks new entries: they would be squashed anyway.
  assign in_ready  = (r_count != 2'd2) && !r_br_taken;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_head_op = r_mem_op[r_rd_ptr];

  // Head finishes this cycle unless it is a write the register file refuses.
  assign w_done = (r_state != S_IDLE) && (!r_rf_we || rf_ready);
  // Another entry can issue right behind the head unless the head squashes it;
  // with one entry buffered the entry arriving on this edge is the next head.
  assign w_more = !r_br_taken && ((r_count == 2'd2) || w_push);

  // Opcode class decode of the entry about to be issued
  assign w_is_alu = (w_sel_op < OP_W'(16));
  assign w_is_br  = !w_is_alu && (w_sel_op < OP_W'(24));
  assign w_we_dec = w_is_alu && (w_sel_rd != '0);
  assign w_br_dec = w_is_br && (w_sel_br != '0);

  // Next-state and next-head selection
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_sel_op     = r_mem_op[r_rd_ptr];
    w_sel_rd     = r_mem_rd[r_rd_ptr];
    w_sel_res    = r_mem_res[r_rd_ptr];
    w_sel_br     = r_mem_br[r_rd_ptr];
    case (r_state)
      S_IDLE: begin
        if (r_count != 2'd0) begin
          w_load       = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      default: begin
        if (w_done) begin
          if (w_more) begin
            w_load       = 1'b1;
            w_state_next = S_ISSUE;
            if (r_count == 2'd2) begin
              w_sel_op  = r_mem_op[~r_rd_ptr];
              w_sel_rd  = r_mem_rd[~r_rd_ptr];
              w_sel_res = r_mem_res[~r_rd_ptr];
              w_sel_br  = r_mem_br[~r_rd_ptr];
            end else begin
              w_sel_op  = in_opcode;
              w_sel_rd  = in_rd;
              w_sel_res = in_result;
              w_sel_br  = in_branch;
            end
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next = S_HOLD;
        end
      end
    endcase
  end

  // Output register next values: load a new head, clear when idle, else hold
  always_comb begin
    w_rf_we_next     = r_rf_we;
    w_rf_waddr_next  = r_rf_waddr;
    w_rf_wdata_next  = r_rf_wdata;
    w_br_taken_next  = r_br_taken;
    w_br_target_next = r_br_target;
    if (w_load) begin
      w_rf_we_next     = w_we_dec;
      w_rf_waddr_next  = w_we_dec ? w_sel_rd : '0;
      w_rf_wdata_next  = w_we_dec ? w_sel_res : '0;
      w_br_taken_next  = w_br_dec;
      w_br_target_next = w_br_dec ? w_sel_br : '0;
    end else if (w_state_next == S_IDLE) begin
      w_rf_we_next     = 1'b0;
      w_rf_waddr_next  = '0;
      w_rf_wdata_next  = '0;
      w_br_taken_next  = 1'b0;
      w_br_target_next = '0;
    end
  end

  // FIFO slot writes; contents need no reset because r_count qualifies them
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_mem_op[gi]  <= in_opcode;
        r_mem_rd[gi]  <= in_rd;
        r_mem_res[gi] <= in_result;
        r_mem_br[gi]  <= in_branch;
      end
    end
  end

  // Pointers, occupancy, FSM, outputs and the retire counter
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_state     <= S_IDLE;
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
      if (rst) begin
        r_retired <= '0;
      end
    end else begin
      r_state     <= w_state_next;
      r_rf_we     <= w_rf_we_next;
      r_rf_waddr  <= w_rf_waddr_next;
      r_rf_wdata  <= w_rf_wdata_next;
      r_br_taken  <= w_br_taken_next;
      r_br_target <= w_br_target_next;
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_done && r_br_taken) begin
        // Taken branch retires and drops everything younger than itself.
        r_count  <= 2'd0;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_done) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        case ({w_push, w_done})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
      if (w_done && (w_head_op != {OP_W{1'b1}})) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;
  assign br_taken  = r_br_taken;
  assign br_target = r_br_target;
  assign retired   = r_retired;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Testbench for alu_writeback_stage: directed scenarios plus random traffic.
// Accepted entries go into an in-order queue; a negedge monitor matches each
// register write / redirect against the oldest visible entry, skipping the
// entries that retire silently, and squashes younger entries on a redirect.
module tb_alu_writeback_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 7;
  localparam int OP_W   = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_opcode;
  logic [REG_W-1:0]  in_rd;
  logic [DATA_W-1:0] in_result;
  logic [REG_W-1:0]  in_branch;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready;
  logic              br_taken;
  logic [REG_W-1:0]  br_target;
  logic [CNT_W-1:0]  retired;

  alu_writeback_stage #(
    .DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_result(in_result), .in_branch(in_branch),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .br_taken(br_taken), .br_target(br_target), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] res;
    logic [REG_W-1:0]  br;
  } ent_t;

  ent_t              pending[$];
  int                wr_cycles[$];
  logic [CNT_W-1:0]  model_ret = '0;
  int                n_total = 0;
  int                n_pass  = 0;
  int                cyc = 0;
  int                wr_events = 0;
  int                br_events = 0;
  bit                hold_prev = 1'b0;
  logic [REG_W-1:0]  hold_addr;
  logic [DATA_W-1:0] hold_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Entries producing a visible output: ALU write to rd!=0, or a taken branch
  function automatic bit visible(input ent_t e);
    return ((e.op < 16) && (e.rd != 0)) || ((e.op >= 16) && (e.op <= 23) && (e.br != 0));
  endfunction

  task automatic expect_event(input bit is_br);
    ent_t e;
    bit   exp_br;
    while (pending.size() > 0 && !visible(pending[0])) begin
      e = pending.pop_front();
      if (e.op != 31) model_ret++;
    end
    if (pending.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_%s: got event expected none (waddr=%0h wdata=%0h target=%0h)",
               is_br ? "branch" : "write", rf_waddr, rf_wdata, br_target);
      return;
    end
    e = pending.pop_front();
    model_ret++;
    exp_br = (e.op >= 16) && (e.op <= 23);
    chk("event_kind", is_br, exp_br);
    if (exp_br) begin
      chk("br_target", br_target, e.br);
      chk("in_ready_during_branch", in_ready, 0);
      pending.delete();
      $display("branch target=%0h", br_target);
    end else begin
      chk("rf_waddr", rf_waddr, e.rd);
      chk("rf_wdata", rf_wdata, e.res);
      $display("write rd=%0d data=%h", rf_waddr, rf_wdata);
    end
  endtask

  // Monitor: outputs are stable at the negedge; acceptance recorded after events
  always @(negedge clk) begin
    if (rst) begin
      pending.delete();
      model_ret = '0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_we", rf_we, 1);
        chk("hold_waddr", rf_waddr, hold_addr);
        chk("hold_wdata", rf_wdata, hold_data);
      end
      if (rf_we && rf_ready) begin
        wr_events++;
        wr_cycles.push_back(cyc);
        expect_event(1'b0);
      end
      if (br_taken) begin
        br_events++;
        expect_event(1'b1);
      end
      hold_prev = rf_we && !rf_ready;
      hold_addr = rf_waddr;
      hold_data = rf_wdata;
      if (flush) begin
        pending.delete();
        hold_prev = 1'b0;
      end else if (in_valid && in_ready) begin
        pending.push_back('{op: in_opcode, rd: in_rd, res: in_result, br: in_branch});
      end
    end
  end

  // Issue one entry; returns #1 after the edge that accepted it
  task automatic send(input logic [OP_W-1:0] op, input logic [REG_W-1:0] rd,
                      input logic [DATA_W-1:0] res, input logic [REG_W-1:0] br);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_result = res; in_branch = br;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
    end
  endtask

  // Let everything retire, then all remaining entries must be silent ones
  task automatic drain(input string tag);
    int lost;
    in_valid = 1'b0;
    rf_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    lost = 0;
    foreach (pending[i]) if (visible(pending[i])) lost++;
    chk({tag, "_lost"}, lost, 0);
    foreach (pending[i]) if (pending[i].op != 31) model_ret++;
    pending.delete();
    chk({tag, "_retired"}, retired, model_ret);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_idle_we"}, rf_we, 0);
    $display("drain %s retired=%0h", tag, retired);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rf_we"}, rf_we, 0);
    chk({tag, "_rf_waddr"}, rf_waddr, 0);
    chk({tag, "_rf_wdata"}, rf_wdata, 0);
    chk({tag, "_br_taken"}, br_taken, 0);
    chk({tag, "_br_target"}, br_target, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_retired"}, retired, 0);
  endtask

  initial begin
    int wbase;
    int bbase;
    logic [OP_W-1:0] op;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; rf_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_result = '0; in_branch = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // ALU writes on consecutive cycles
    wr_cycles.delete();
    send(5'd3, 7'd5, 32'h0000_00AA, 7'd0);
    send(5'd1, 7'd6, 32'hFFFF_FFFF, 7'd0);
    drain("t2");
    chk("t2_write_count", wr_cycles.size(), 2);
    if (wr_cycles.size() >= 2) chk("t2_consecutive", wr_cycles[1] - wr_cycles[0], 1);

    // Back-pressure: third entry stalls, outputs held, nothing lost
    rf_ready = 1'b0;
    send(5'd4, 7'd10, 32'h1111_0001, 7'd0);
    send(5'd5, 7'd11, 32'h2222_0002, 7'd0);
    in_valid = 1'b1; in_opcode = 5'd6; in_rd = 7'd12; in_result = 32'h3333_0003; in_branch = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_full_in_ready", in_ready, 0);
    chk("t3_hold_we", rf_we, 1);
    rf_ready = 1'b1;
    send(5'd6, 7'd12, 32'h3333_0003, 7'd0);
    drain("t3");

    // Taken branch squashes the younger write; not-taken branch is silent
    bbase = br_events; wbase = wr_events;
    send(5'd16, 7'd0, 32'h0, 7'h12);
    send(5'd2, 7'd7, 32'h0000_0077, 7'd0);
    drain("t4a");
    chk("t4_taken_count", br_events - bbase, 1);
    chk("t4_squashed_write", wr_events - wbase, 0);
    send(5'd16, 7'd0, 32'h0, 7'd0);
    drain("t4b");
    chk("t4_not_taken", br_events - bbase, 1);

    // rd0, NOP and NOWB never write
    wbase = wr_events;
    send(5'd0, 7'd0, 32'hDEAD_BEEF, 7'd0);
    send(5'd31, 7'd3, 32'h1234_5678, 7'd0);
    send(5'd25, 7'd4, 32'h8765_4321, 7'd0);
    drain("t5");
    chk("t5_no_write", wr_events - wbase, 0);

    // Mid-stream reset
    rf_ready = 1'b0;
    send(5'd7, 7'd20, 32'hAAAA_5555, 7'd0);
    send(5'd8, 7'd21, 32'h5555_AAAA, 7'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("t1_mid");
    rst = 1'b0;
    rf_ready = 1'b1;

    // Random traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      rf_ready = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: op = 5'($urandom_range(0, 15));
        6, 7:             op = 5'($urandom_range(16, 23));
        8:                op = 5'($urandom_range(24, 30));
        default:          op = 5'd31;
      endcase
      in_opcode = op;
      in_rd     = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      in_result = $urandom;
      in_branch = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      @(posedge clk);
      #1;
    end
    drain("random");

    // Counter wrap
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 65535; i++) send(5'd25, 7'd1, 32'(i), 7'd0);
    drain("t6_preload");
    chk("t6_full", retired, 16'hFFFF);
    send(5'd24, 7'd1, 32'h0, 7'd0);
    drain("t6_wrap");
    chk("t6_wrapped", retired, 16'h0000);

    // Flush with simultaneous push drops the entry
    wbase = wr_events;
    in_valid = 1'b1; in_opcode = 5'd3; in_rd = 7'd9; in_result = 32'hCAFE_F00D; in_branch = '0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    drain("t6_flush");
    chk("t6_flush_dropped", wr_events - wbase, 0);
    chk("t6_flush_retired", retired, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
